fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-address producer for the RV32IM single-cycle core. It is the upstream end of the decoder's instruction interface: it holds the PC and drives the instruction-memory address whose fetched word feeds the control unit. Each cycle it computes the next PC from the decoded TargetSel, the register operands and the immediate. It resolves branches, JAL and JALR internally and raises a trap redirect on a misaligned target. It also keeps a retired-instruction counter.

Parameters:
WIDTH, 32, datapath and address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned-target trap

Ports:
clk  input  1  core clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
Stall  input  1  hold PC this cycle (memory or multiply/divide busy)
TargetSel  input  4  next-PC selector from the control unit
Rs1Data  input  WIDTH  register-file read port 1
Rs2Data  input  WIDTH  register-file read port 2
Immediate  input  WIDTH  sign-extended immediate from the immediate generator
PC  output  WIDTH  current PC, also the instruction-memory address
PCPlus4  output  WIDTH  PC+4, used for the JAL/JALR link write-back
InstrValid  output  1  the word fetched at PC is to be executed this cycle
BranchTaken  output  1  the redirect is taken this cycle (combinational)
MisalignTrap  output  1  a trap is being taken this cycle (combinational)
MEPC  output  WIDTH  PC of the instruction that trapped
InstrCount  output  WIDTH  count of retired instructions

Behaviour:
- TargetSel codes, from the shared control-codes header:
  - TR_NOP=0000
  - BR_EQ=0001, BR_NE=0010, BR_LT=0011, BR_GE=0100, BR_LTU=0101, BR_GEU=0110
  - UJ_AL=0111, UJ_ALR=1000
  - Codes 1001-1111 behave as TR_NOP.
- Reset (rst_n low, asynchronous): PC=RESET_VECTOR, MEPC=0, InstrCount=0, state=BOOT.
- Outputs while reset is asserted: InstrValid=0, BranchTaken=0, MisalignTrap=0.
- Branch compares:
  - BR_EQ and BR_NE compare Rs1Data with Rs2Data for equality.
  - BR_LT and BR_GE are signed.
  - BR_LTU and BR_GEU are unsigned.
- Targets (all addition is modulo 2^WIDTH; wrap-around is legal):
  - Branches and UJ_AL: PC+Immediate.
  - UJ_ALR: (Rs1Data+Immediate) with bit 0 cleared.
  - Sequential: PC+4.
- Taken condition: TargetSel is UJ_AL, UJ_ALR, or a branch whose compare is true.
- Misaligned: the selected taken target has bits [1:0] not equal to 00. The check is applied after the JALR bit-0 clear, so the JALR check effectively uses bit 1 only. No C extension is supported.
- States:
  - BOOT: InstrValid=0, PC held. Next state is RUN unconditionally; Stall is ignored in BOOT.
  - RUN: InstrValid=1.
    - Stall=1: PC, MEPC and InstrCount hold. BranchTaken=0 and MisalignTrap=0, even if the redirect condition is true. Stall overrides redirect and trap.
    - Stall=0, not taken: PC <= PC+4 and InstrCount increments.
    - Stall=0, taken, aligned target: PC <= target, BranchTaken=1, InstrCount increments.
    - Stall=0, taken, misaligned target: MisalignTrap=1, BranchTaken=0, MEPC <= PC, PC <= TRAP_VECTOR, next state is TRAP. InstrCount does not increment because the trapping instruction does not retire.
  - TRAP: one bubble cycle. InstrValid=0, PC held at TRAP_VECTOR, no count, inputs ignored. Next state is RUN.
- Output timing: PCPlus4 is combinational PC+4 in every state. BranchTaken and MisalignTrap are combinational and forced to 0 outside RUN.
- InstrCount wraps from all-ones to 0.
- Reset asserted mid-operation, including in TRAP: immediately returns to the reset values; the first cycle after release is BOOT.

Test Plan:
- Reset release, Stall=0, TargetSel=TR_NOP for 4 cycles -> PC sequence 0x0 (BOOT, InstrValid=0), 0x0, 0x4, 0x8, 0xC; InstrCount=3 when PC=0xC.
- Branches at PC=0x20, Immediate=0xFFFFFFF0, Rs1=0xFFFFFFFF, Rs2=0x1:
  - BR_LT -> next PC 0x10, BranchTaken=1.
  - BR_LTU -> next PC 0x24, BranchTaken=0.
  - BR_EQ with Rs1=Rs2=5 -> next PC 0x10.
- UJ_ALR at PC=0x40, Rs1=0x1001, Immediate=0x4 -> next PC 0x1004, PCPlus4=0x44 in that cycle.
- UJ_AL at PC=0x80, Immediate=0x6 -> MisalignTrap=1, then MEPC=0x80, PC=0x100, one cycle with InstrValid=0, then PC 0x104; InstrCount unchanged across the trap.
- Stall=1 with BR_EQ taken at PC=0x10 for 3 cycles -> PC stays 0x10, BranchTaken=0 throughout; after Stall falls, the next PC is the branch target.
- rst_n pulsed low during the TRAP cycle -> PC=0x0, MEPC=0, InstrCount=0 immediately (asynchronously); the first cycle after release has InstrValid=0.
- Wrap-around at PC=0xFFFFFFFC, TR_NOP -> next PC 0x0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// PC register, next-PC selection (sequential, branch, JAL, JALR), misaligned-target
// trap redirect and retired-instruction counter for the single-cycle RV32IM core.
module fetch_pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Stall,
  input  logic [3:0]       TargetSel,
  input  logic [WIDTH-1:0] Rs1Data,
  input  logic [WIDTH-1:0] Rs2Data,
  input  logic [WIDTH-1:0] Immediate,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             InstrValid,
  output logic             BranchTaken,
  output logic             MisalignTrap,
  output logic [WIDTH-1:0] MEPC,
  output logic [WIDTH-1:0] InstrCount,
  output logic [1:0]       dbg_state_o
);

  localparam logic [3:0] BR_EQ  = 4'b0001;
  localparam logic [3:0] BR_NE  = 4'b0010;
  localparam logic [3:0] BR_LT  = 4'b0011;
  localparam logic [3:0] BR_GE  = 4'b0100;
  localparam logic [3:0] BR_LTU = 4'b0101;
  localparam logic [3:0] BR_GEU = 4'b0110;
  localparam logic [3:0] UJ_AL  = 4'b0111;
  localparam logic [3:0] UJ_ALR = 4'b1000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mepc_q, mepc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] target;
  logic             taken;
  logic             misaligned;
  logic             redirect;

  assign pc_plus4  = pc_q + WIDTH'(4);
  assign br_target = pc_q + Immediate;
  assign jalr_sum  = Rs1Data + Immediate;
  // JALR clears bit 0 before the alignment check, so only bit 1 can trap.
  assign target     = (TargetSel == UJ_ALR) ? {jalr_sum[WIDTH-1:1], 1'b0} : br_target;
  assign misaligned = (target[1:0] != 2'b00);

  always_comb begin
    taken = 1'b0;
    case (TargetSel)
      BR_EQ:         taken = (Rs1Data == Rs2Data);
      BR_NE:         taken = (Rs1Data != Rs2Data);
      BR_LT:         taken = ($signed(Rs1Data) <  $signed(Rs2Data));
      BR_GE:         taken = ($signed(Rs1Data) >= $signed(Rs2Data));
      BR_LTU:        taken = (Rs1Data <  Rs2Data);
      BR_GEU:        taken = (Rs1Data >= Rs2Data);
      UJ_AL, UJ_ALR: taken = 1'b1;
      default:       taken = 1'b0;
    endcase
  end

  // Stall masks both the redirect and the trap.
  assign redirect     = (state_q == ST_RUN) && !Stall && taken;
  assign BranchTaken  = redirect && !misaligned;
  assign MisalignTrap = redirect && misaligned;
  assign InstrValid   = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mepc_d  = mepc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_TRAP: state_d = ST_RUN;
      ST_RUN: begin
        if (!Stall) begin
          if (MisalignTrap) begin
            mepc_d  = pc_q;
            pc_d    = TRAP_VECTOR;
            state_d = ST_TRAP;
          end else begin
            pc_d  = BranchTaken ? target : pc_plus4;
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      mepc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mepc_q  <= mepc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign MEPC        = mepc_q;
  assign InstrCount  = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit against an architectural next-PC model.
module tb_fetch_pc_unit;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
  logic [31:0] pc, pc_plus4, mepc, icount;
  logic        ivalid, btaken, mtrap;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Architectural model: phase 0 = boot bubble, 1 = executing, 2 = trap bubble.
  int          m_phase;
  logic [31:0] m_pc, m_mepc, m_cnt;
  logic [31:0] saved_cnt;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .Stall(stall), .TargetSel(sel),
    .Rs1Data(rs1), .Rs2Data(rs2), .Immediate(imm),
    .PC(pc), .PCPlus4(pc_plus4), .InstrValid(ivalid), .BranchTaken(btaken),
    .MisalignTrap(mtrap), .MEPC(mepc), .InstrCount(icount), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_mepc  = 32'h0;
    m_cnt   = 32'h0;
  endtask

  // Reset asserted mid-cycle, checked asynchronously, released just after a rising edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_mepc", mepc, 32'h0);
    check("rst_cnt", icount, 32'h0);
    check("rst_valid", {31'b0, ivalid}, 32'h0);
    check("rst_btaken", {31'b0, btaken}, 32'h0);
    check("rst_mtrap", {31'b0, mtrap}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input logic s, input logic [3:0] ts, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im);
    logic        cond, exec, e_bt, e_mt;
    logic [31:0] tgt;
    @(negedge clk);
    stall = s; sel = ts; rs1 = a; rs2 = b; imm = im;
    case (ts)
      4'd1:     cond = (a == b);
      4'd2:     cond = (a != b);
      4'd3:     cond = ($signed(a) < $signed(b));
      4'd4:     cond = ($signed(a) >= $signed(b));
      4'd5:     cond = (a < b);
      4'd6:     cond = (a >= b);
      4'd7:     cond = 1'b1;
      4'd8:     cond = 1'b1;
      default:  cond = 1'b0;
    endcase
    tgt  = (ts == 4'd8) ? ((a + im) & 32'hFFFF_FFFE) : (m_pc + im);
    exec = (m_phase == 1) && !s;
    e_bt = exec && cond && (tgt % 4 == 0);
    e_mt = exec && cond && (tgt % 4 != 0);
    #1;
    check("pc", pc, m_pc);
    check("pcplus4", pc_plus4, m_pc + 32'd4);
    check("valid", {31'b0, ivalid}, {31'b0, m_phase == 1});
    check("btaken", {31'b0, btaken}, {31'b0, e_bt});
    check("mtrap", {31'b0, mtrap}, {31'b0, e_mt});
    check("mepc", mepc, m_mepc);
    check("cnt", icount, m_cnt);
    if (m_phase != 1) m_phase = 1;
    else if (exec) begin
      if (e_mt) begin
        m_mepc  = m_pc;
        m_pc    = TRAP_VEC;
        m_phase = 2;
      end else begin
        m_pc  = e_bt ? tgt : m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r1, r2, ri;
    model_reset();
    do_reset();

    // Boot bubble then three sequential fetches.
    repeat (4) step(0, 4'd0, 0, 0, 0);
    check("seq_pc", pc, 32'hC);
    check("seq_cnt", icount, 32'd3);

    // Branch compares at PC=0x20.
    step(0, 4'd7, 0, 0, 32'h14);
    check("jal_pc20", pc, 32'h20);
    step(0, 4'd3, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0);
    check("blt_pc", pc, 32'h10);
    step(0, 4'd7, 0, 0, 32'h10);
    step(0, 4'd5, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0);
    check("bltu_pc", pc, 32'h24);
    step(0, 4'd7, 0, 0, 32'hFFFF_FFFC);
    step(0, 4'd1, 32'd5, 32'd5, 32'hFFFF_FFF0);
    check("beq_pc", pc, 32'h10);

    // Stall holds PC and suppresses the taken branch.
    repeat (3) step(1, 4'd1, 32'd7, 32'd7, 32'h30);
    check("stall_pc", pc, 32'h10);
    step(0, 4'd1, 32'd7, 32'd7, 32'h30);
    check("post_stall_pc", pc, 32'h40);

    // JALR with bit-0 clear.
    step(0, 4'd8, 32'h1001, 0, 32'h4);
    check("jalr_pc", pc, 32'h1004);

    // Misaligned JAL traps.
    step(0, 4'd8, 32'h80, 0, 0);
    saved_cnt = icount;
    step(0, 4'd7, 0, 0, 32'h6);
    check("trap_pc", pc, 32'h100);
    check("trap_mepc", mepc, 32'h80);
    check("trap_cnt", icount, saved_cnt);
    step(0, 4'd7, 0, 0, 32'h40);
    step(0, 4'd0, 0, 0, 0);
    check("after_trap_pc", pc, 32'h104);
    check("after_trap_cnt", icount, saved_cnt + 32'd1);

    // Reset during the trap bubble.
    step(0, 4'd7, 0, 0, 32'h2);
    check("trap2_pc", pc, 32'h100);
    do_reset();
    step(0, 4'd0, 0, 0, 0);

    // PC wrap-around.
    step(0, 4'd8, 32'hFFFF_FFFC, 0, 0);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    step(0, 4'd0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      ri = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), r1, r2, ri);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
